// File: rtl/coprocessor_debug_host.sv
// coprocessor_debug_host: host-side initiator for the core's coprocessor debug port.
// Turns host commands (valid/ready) into cycle-exact coprocessorIO* sequences
// and returns read data / status on a valid/ready response channel.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op/cmd_addr/cmd_data       0 HALT 1 RESUME 2 MEM_WR 3 MEM_RD
//                                  4 REG_WR 5 REG_RD 6 SET_BKPT 7 CLR_BKPT
//   rsp_valid/rsp_ready            response handshake
//   rsp_data/rsp_err               read data (0 for non-reads), reject flag
//   coprocessorIOAddr/Control      to core; Control = {bkpt armed, reg wr,
//   coprocessorIODataOut           dmem rd, dmem wr, halt}
//   coprocessorIODataIn            from core
//   coprocessorIODebugFlags        [0] cycle-breakpoint hit, [1] ebreak seen
//   halted, bkpt_hit               halt mirror, registered breakpoint hit
//
// Optional feature macro: COP_AUTOHALT_EN (halt automatically on ebreak).

module coprocessor_debug_host #(
    parameter int N      = 64,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [14:0]  cmd_addr,
    input  logic [N-1:0] cmd_data,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err,
    output logic [14:0]  coprocessorIOAddr,
    output logic [4:0]   coprocessorIOControl,
    output logic [N-1:0] coprocessorIODataOut,
    input  logic [N-1:0] coprocessorIODataIn,
    input  logic [1:0]   coprocessorIODebugFlags,
    output logic         halted,
    output logic         bkpt_hit
);

    localparam logic [2:0] OP_HALT   = 3'd0;
    localparam logic [2:0] OP_RESUME = 3'd1;
    localparam logic [2:0] OP_MEM_WR = 3'd2;
    localparam logic [2:0] OP_MEM_RD = 3'd3;
    localparam logic [2:0] OP_REG_WR = 3'd4;
    localparam logic [2:0] OP_REG_RD = 3'd5;
    localparam logic [2:0] OP_SET_BK = 3'd6;
    localparam logic [2:0] OP_CLR_BK = 3'd7;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]   state;
    logic [2:0]   op_q;
    logic [14:0]  addr_q;
    logic [N-1:0] data_q;
    logic         halt_q;
    logic         bkpt_q;
    logic         intl_q;
    logic [1:0]   cnt;

    logic         is_acc;
    logic         acc_ok;
    logic         is_rd;
    logic         auto_go;
    logic         ctrl_mw;
    logic         ctrl_mr;
    logic         ctrl_rw;

    // dmem/register accesses are only legal while the core is halted
    assign is_acc = (op_q == OP_MEM_WR) || (op_q == OP_MEM_RD) ||
                    (op_q == OP_REG_WR) || (op_q == OP_REG_RD);
    assign acc_ok = is_acc && halt_q;
    assign is_rd  = acc_ok && ((op_q == OP_MEM_RD) || (op_q == OP_REG_RD));

`ifdef COP_AUTOHALT_EN
    logic flag1_q;
    logic pend_q;
    logic ebrk_rise;

    assign ebrk_rise = coprocessorIODebugFlags[1] && !flag1_q;
    // an ebreak seen mid-command is remembered and serviced on return to IDLE
    assign auto_go   = (state == S_IDLE) && (pend_q || ebrk_rise);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag1_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            flag1_q <= coprocessorIODebugFlags[1];
            if (auto_go)
                pend_q <= 1'b0;
            else if (ebrk_rise)
                pend_q <= 1'b1;
        end
    end
`else
    logic unused_ebrk;
    assign unused_ebrk = coprocessorIODebugFlags[1];
    assign auto_go     = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE) && !reset && !auto_go;
    assign rsp_valid = (state == S_RESP);
    assign halted    = halt_q;

    always_comb begin
        ctrl_mw              = 1'b0;
        ctrl_mr              = 1'b0;
        ctrl_rw              = 1'b0;
        coprocessorIOAddr    = '0;
        coprocessorIODataOut = '0;
        if (state == S_ISSUE) begin
            ctrl_mw = acc_ok && (op_q == OP_MEM_WR);
            ctrl_rw = (acc_ok && (op_q == OP_REG_WR)) || (op_q == OP_SET_BK);
            if (ctrl_mw || ctrl_rw)
                coprocessorIODataOut = data_q;
        end
        if ((state == S_ISSUE) || (state == S_WAIT)) begin
            ctrl_mr = acc_ok && (op_q == OP_MEM_RD);
            if (acc_ok || (op_q == OP_SET_BK))
                coprocessorIOAddr = addr_q;
        end
    end

    assign coprocessorIOControl = {bkpt_q, ctrl_rw, ctrl_mr, ctrl_mw, halt_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= OP_HALT;
            addr_q   <= '0;
            data_q   <= '0;
            halt_q   <= 1'b0;
            bkpt_q   <= 1'b0;
            intl_q   <= 1'b0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            bkpt_hit <= 1'b0;
        end else begin
            bkpt_hit <= coprocessorIODebugFlags[0];
            case (state)
                S_IDLE: begin
                    if (auto_go) begin
                        // internal REG_WR that clears the core's ebreak flag
                        halt_q <= 1'b1;
                        op_q   <= OP_REG_WR;
                        addr_q <= 15'h1001;
                        data_q <= '0;
                        intl_q <= 1'b1;
                        state  <= S_ISSUE;
                    end else if (cmd_valid && cmd_ready) begin
                        op_q   <= cmd_op;
                        addr_q <= (cmd_op == OP_SET_BK) ? 15'h1000 : cmd_addr;
                        data_q <= cmd_data;
                        intl_q <= 1'b0;
                        state  <= S_ISSUE;
                        // halt/bkpt bits become visible in the ISSUE cycle
                        if (cmd_op == OP_HALT)   halt_q <= 1'b1;
                        if (cmd_op == OP_RESUME) halt_q <= 1'b0;
                        if (cmd_op == OP_SET_BK) bkpt_q <= 1'b1;
                        if (cmd_op == OP_CLR_BK) bkpt_q <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    rsp_data <= '0;
                    rsp_err  <= is_acc && !halt_q;
                    intl_q   <= 1'b0;
                    if (intl_q) begin
                        state <= S_IDLE;
                    end else if (is_rd) begin
                        if (RD_LAT == 0) begin
                            rsp_data <= coprocessorIODataIn;
                            state    <= S_RESP;
                        end else begin
                            cnt   <= 2'd1;
                            state <= S_WAIT;
                        end
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'(RD_LAT)) begin
                        rsp_data <= coprocessorIODataIn;
                        state    <= S_RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coprocessor_debug_host.sv
// tb_coprocessor_debug_host: directed + random command sequences checked
// against a transaction-level model of halt state, dmem and registers.

module tb_coprocessor_debug_host;

    localparam int          N      = 64;
    localparam int          RD_LAT = 1;
    localparam logic [63:0] PC     = 64'h400;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [14:0]  cmd_addr;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_err;
    logic [14:0]  io_addr;
    logic [4:0]   io_ctl;
    logic [N-1:0] io_dout;
    logic [N-1:0] io_din;
    logic [1:0]   io_flags;
    logic         halted;
    logic         bkpt_hit;

    always #5 clk = ~clk;

    coprocessor_debug_host #(.N(N), .RD_LAT(RD_LAT)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_op                 (cmd_op),
        .cmd_addr               (cmd_addr),
        .cmd_data               (cmd_data),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_data               (rsp_data),
        .rsp_err                (rsp_err),
        .coprocessorIOAddr      (io_addr),
        .coprocessorIOControl   (io_ctl),
        .coprocessorIODataOut   (io_dout),
        .coprocessorIODataIn    (io_din),
        .coprocessorIODebugFlags(io_flags),
        .halted                 (halted),
        .bkpt_hit               (bkpt_hit)
    );

    // Core stand-in: dmem and a small register file behind the debug port
    logic [63:0] cmem [256] = '{default: '0};
    logic [63:0] creg [32]  = '{default: '0};

    always @(posedge clk) begin
        if (io_ctl[1]) cmem[io_addr[7:0]] <= io_dout;
        if (io_ctl[3] && io_addr < 15'd32) creg[io_addr[4:0]] <= io_dout;
    end

    assign io_din = io_ctl[2] ? cmem[io_addr[7:0]] :
                    (io_addr[5] ? PC : creg[io_addr[4:0]]);

    // Strobe monitor: counts strobe cycles and remembers last write payloads
    int          n_mw = 0;
    int          n_mr = 0;
    int          n_rw = 0;
    logic [14:0] mw_addr = '0;
    logic [63:0] mw_data = '0;
    logic [14:0] rw_addr = '0;
    logic [63:0] rw_data = '0;

    always @(posedge clk) begin
        if (!reset) begin
            if (io_ctl[1]) begin
                n_mw    = n_mw + 1;
                mw_addr = io_addr;
                mw_data = io_dout;
            end
            if (io_ctl[2]) n_mr = n_mr + 1;
            if (io_ctl[3]) begin
                n_rw    = n_rw + 1;
                rw_addr = io_addr;
                rw_data = io_dout;
            end
        end
    end

    // Reference model state
    logic        m_halt;
    logic        m_bkpt;
    logic [63:0] m_mem [256];
    logic [63:0] m_reg [32];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input logic [2:0] op, input logic [14:0] a,
                       input logic [63:0] d);
        logic        acc;
        logic        err;
        logic [63:0] xd;
        int          xl;
        int          xmw;
        int          xmr;
        int          xrw;
        int          mw0;
        int          mr0;
        int          rw0;
        int          t;
        int          lat;
        int          hold;
        logic [65:0] snap;

        acc = (op >= 3'd2) && (op <= 3'd5);
        err = acc && !m_halt;
        xd  = '0;
        xl  = 2;
        if (!err && op == 3'd3) begin
            xd = m_mem[a[7:0]];
            xl = RD_LAT + 2;
        end
        if (!err && op == 3'd5) begin
            xd = a[5] ? PC : m_reg[a[4:0]];
            xl = RD_LAT + 2;
        end
        xmw = (op == 3'd2 && !err) ? 1 : 0;
        xmr = (op == 3'd3 && !err) ? RD_LAT + 1 : 0;
        xrw = ((op == 3'd4 && !err) || op == 3'd6) ? 1 : 0;
        case (op)
            3'd0: m_halt = 1'b1;
            3'd1: m_halt = 1'b0;
            3'd2: if (!err) m_mem[a[7:0]] = d;
            3'd4: if (!err && a < 15'd32) m_reg[a[4:0]] = d;
            3'd6: m_bkpt = 1'b1;
            3'd7: m_bkpt = 1'b0;
            default: ;
        endcase

        @(negedge clk);
        mw0       = n_mw;
        mr0       = n_mr;
        rw0       = n_rw;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
        chk("latency", 64'(lat), 64'(xl));
        chk("rsp_err", 64'(rsp_err), 64'(err));
        chk("rsp_data", rsp_data, xd);
        snap = {rsp_valid, rsp_err, rsp_data};
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_hold", snap[63:0], rsp_data);
            chk("rsp_hold_v", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", 64'(rsp_valid), 64'd0);
        chk("n_memwr", 64'(n_mw - mw0), 64'(xmw));
        chk("n_memrd", 64'(n_mr - mr0), 64'(xmr));
        chk("n_regwr", 64'(n_rw - rw0), 64'(xrw));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("bkpt_arm", 64'(io_ctl[4]), 64'(m_bkpt));
        chk("idle_strb", 64'(io_ctl[3:1]), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [14:0] ra;
        logic [63:0] rd;
        int          mw0;
        int          mr0;
        int          rw0;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        io_flags  = '0;
        m_halt    = 1'b0;
        m_bkpt    = 1'b0;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_ctrl", 64'(io_ctl), 64'd0);
        chk("rst_rspv", 64'(rsp_valid), 64'd0);
        chk("rst_ready1", 64'(cmd_ready), 64'd1);
        chk("rst_rspd", rsp_data, 64'd0);
        chk("rst_bkhit", 64'(bkpt_hit), 64'd0);

        // access while running is rejected
        txn(3'd3, 15'h0010, 64'd0);

        // halted dmem write then read back
        txn(3'd0, 15'h0, 64'd0);
        txn(3'd2, 15'h0018, 64'hDEAD_BEEF);
        chk("mw_addr", 64'(mw_addr), 64'h18);
        chk("mw_data", mw_data, 64'hDEAD_BEEF);
        txn(3'd3, 15'h0018, 64'd0);

        // PC read through register path
        txn(3'd5, 15'h0020, 64'd0);

        // breakpoint arm, hit, clear
        txn(3'd6, 15'h0, 64'd100);
        chk("bk_addr", 64'(rw_addr), 64'h1000);
        chk("bk_data", rw_data, 64'd100);
        txn(3'd1, 15'h0, 64'd0);
        @(negedge clk);
        io_flags = 2'b01;
        @(negedge clk);
        chk("bkpt_hit1", 64'(bkpt_hit), 64'd1);
        io_flags = 2'b00;
        @(negedge clk);
        chk("bkpt_hit0", 64'(bkpt_hit), 64'd0);
        txn(3'd7, 15'h0, 64'd0);

        // random command mix
        for (int k = 0; k < 120; k++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd4 || rop == 3'd5)
                ra = 15'($urandom_range(0, 32));
            else
                ra = 15'($urandom_range(0, 255));
            rd = {$urandom, $urandom};
            txn(rop, ra, rd);
        end

        // reset in the middle of a read
        txn(3'd0, 15'h0, 64'd0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        cmd_addr  = 15'h0005;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rd", 64'(io_ctl[2]), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_ctrl", 64'(io_ctl), 64'd0);
        chk("mid_rspv", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        mw0 = n_mw;
        mr0 = n_mr;
        rw0 = n_rw;
        repeat (4) @(negedge clk);
        chk("mid_norsp", 64'(rsp_valid), 64'd0);
        chk("mid_nostrb", 64'((n_mw - mw0) + (n_mr - mr0) + (n_rw - rw0)),
            64'd0);
        m_halt = 1'b0;
        m_bkpt = 1'b0;
        txn(3'd3, 15'h0005, 64'd0);

`ifdef COP_AUTOHALT_EN
        // ebreak rising edge in IDLE halts and clears the flag
        @(negedge clk);
        io_flags = 2'b10;
        @(negedge clk);
        chk("ah_halt", 64'(halted), 64'd1);
        chk("ah_strb", 64'(io_ctl[3]), 64'd1);
        chk("ah_addr", 64'(io_addr), 64'h1001);
        chk("ah_data", io_dout, 64'd0);
        @(negedge clk);
        chk("ah_strb0", 64'(io_ctl[3]), 64'd0);
        chk("ah_ready", 64'(cmd_ready), 64'd1);
        io_flags = 2'b00;
        m_halt = 1'b1;
        txn(3'd3, 15'h0018, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
